// File: rtl/expu_pkg.sv
// rtl/expu_pkg.sv - shared types and width helpers for the exp-sum accumulator
package expu_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_e;

    function automatic int expu_bias(input int exponent_bits);
        return (1 << (exponent_bits - 1)) - 1;
    endfunction

    function automatic int expu_acc_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

endpackage

// File: rtl/expu_float2fixed.sv
// rtl/expu_float2fixed.sv - combinational {exponent, mantissa} to unsigned fixed-point conversion
module expu_float2fixed
    import expu_pkg::*;
#(
    parameter int MANTISSA_BITS = 7,
    parameter int EXPONENT_BITS = 8,
    parameter int ACC_INT_BITS  = 16,
    parameter int ACC_FRAC_BITS = 16,
    localparam int ACC_W        = expu_acc_width(ACC_INT_BITS, ACC_FRAC_BITS)
) (
    input  logic [MANTISSA_BITS-1:0] mantissa_i,
    input  logic [EXPONENT_BITS-1:0] exponent_i,
    output logic [ACC_W-1:0]         value_o,
    output logic                     ovf_o
);

    localparam int BIAS  = expu_bias(EXPONENT_BITS);
    localparam int SIG_W = MANTISSA_BITS + 1;

    logic [ACC_W-1:0] sig_ext;
    int               shift;

    assign sig_ext = ACC_W'({1'b1, mantissa_i});

    // shift places the hidden-one significand onto the accumulator's binary point
    always_comb begin
        shift   = int'(exponent_i) - BIAS + ACC_FRAC_BITS - MANTISSA_BITS;
        value_o = '0;
        ovf_o   = 1'b0;
        if (exponent_i == '0) begin
            value_o = '0;
        end else if (&exponent_i) begin
            ovf_o = 1'b1;
        end else if (shift >= 0) begin
            if (shift + SIG_W > ACC_W) begin
                ovf_o = 1'b1;
            end else begin
                value_o = sig_ext << shift;
            end
        end else if (-shift < SIG_W) begin
            value_o = sig_ext >> (-shift);
        end
    end

endmodule

// File: rtl/expu_sum_accumulator.sv
// rtl/expu_sum_accumulator.sv - packet accumulator of exp results; EXPU_ACC_SATURATE_EN selects saturating sum
module expu_sum_accumulator
    import expu_pkg::*;
#(
    parameter int MANTISSA_BITS = 7,
    parameter int EXPONENT_BITS = 8,
    parameter int ACC_INT_BITS  = 16,
    parameter int ACC_FRAC_BITS = 16,
    parameter int CNT_BITS      = 16,
    localparam int ACC_W        = expu_acc_width(ACC_INT_BITS, ACC_FRAC_BITS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     last_i,
    input  logic [MANTISSA_BITS-1:0] mantissa_i,
    input  logic [EXPONENT_BITS-1:0] exponent_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [ACC_W-1:0]         sum_o,
    output logic [CNT_BITS-1:0]      count_o,
    output logic                     ovf_o
);

    acc_state_e          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                ovf_q, ovf_d;

    logic [ACC_W-1:0]    conv_value;
    logic                beat_ovf;
    logic [ACC_W:0]      sum_w;
    logic                carry;
    logic [ACC_W-1:0]    acc_next;

    expu_float2fixed #(
        .MANTISSA_BITS(MANTISSA_BITS),
        .EXPONENT_BITS(EXPONENT_BITS),
        .ACC_INT_BITS (ACC_INT_BITS),
        .ACC_FRAC_BITS(ACC_FRAC_BITS)
    ) u_float2fixed (
        .mantissa_i(mantissa_i),
        .exponent_i(exponent_i),
        .value_o   (conv_value),
        .ovf_o     (beat_ovf)
    );

    assign sum_w = {1'b0, acc_q} + {1'b0, conv_value};
    assign carry = sum_w[ACC_W];

`ifdef EXPU_ACC_SATURATE_EN
    // once saturated the sum pins at all-ones for the rest of the packet
    assign acc_next = (ovf_q || beat_ovf || carry) ? '1 : sum_w[ACC_W-1:0];
`else
    assign acc_next = beat_ovf ? acc_q : sum_w[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        ready_o = (state_q == ACCUM);
        valid_o = (state_q == HOLD);
        if (clear_i) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (valid_i) begin
                        acc_d   = acc_next;
                        count_d = count_q + CNT_BITS'(1);
                        ovf_d   = ovf_q | beat_ovf | carry;
                        if (last_i) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum_o   = acc_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_expu_sum_accumulator.sv
// tb/tb_expu_sum_accumulator.sv - directed scoreboard bench for expu_sum_accumulator
module tb_expu_sum_accumulator;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        valid_i;
    logic        ready_o;
    logic        last_i;
    logic [6:0]  mantissa_i;
    logic [7:0]  exponent_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] sum_o;
    logic [15:0] count_o;
    logic        ovf_o;

    typedef struct packed {
        logic [31:0] sum;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    expu_sum_accumulator dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .last_i    (last_i),
        .mantissa_i(mantissa_i),
        .exponent_i(exponent_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sum_o     (sum_o),
        .count_o   (count_o),
        .ovf_o     (ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] e, input logic [6:0] m, input logic l);
        exponent_i = e;
        mantissa_i = m;
        last_i     = l;
        valid_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i    = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] s, input logic [15:0] c, input logic o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        sb_q.push_back(e);
    endtask

    task automatic check_pkt(input string tag);
        exp_t e;
        int   waited;
        waited = 0;
        while (valid_o !== 1'b1 && waited < 20) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        chk({tag, "_latency"}, 64'(waited), 64'h0);
        if (valid_o === 1'b1) begin
            chk({tag, "_ready_hold"}, 64'(ready_o), 64'h0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "_sum"}, 64'(sum_o), 64'(e.sum));
                chk({tag, "_count"}, 64'(count_o), 64'(e.cnt));
                chk({tag, "_ovf"}, 64'(ovf_o), 64'(e.ovf));
            end
            ready_i = 1'b1;
            @(posedge clk_i);
            #1;
            chk({tag, "_valid_drop"}, 64'(valid_o), 64'h0);
            chk({tag, "_ready_back"}, 64'(ready_o), 64'h1);
            chk({tag, "_sum_clr"}, 64'(sum_o), 64'h0);
        end
    endtask

    initial begin
        rst_ni     = 1'b0;
        clear_i    = 1'b0;
        valid_i    = 1'b0;
        last_i     = 1'b0;
        mantissa_i = '0;
        exponent_i = '0;
        ready_i    = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_ready", 64'(ready_o), 64'h1);
        chk("rst_sum", 64'(sum_o), 64'h0);
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_ovf", 64'(ovf_o), 64'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        push_exp(32'h0004_0000, 16'd4, 1'b0);
        for (int i = 0; i < 3; i++) beat(8'd127, 7'h00, 1'b0);
        beat(8'd127, 7'h00, 1'b1);
        check_pkt("four_ones");

        push_exp(32'h0001_8000, 16'd3, 1'b0);
        beat(8'd127, 7'h40, 1'b0);
        beat(8'd107, 7'h00, 1'b0);
        beat(8'd0, 7'h00, 1'b1);
        check_pkt("trunc_flush");

        push_exp(32'h0000_0355, 16'd3, 1'b0);
        beat(8'd120, 7'h55, 1'b0);
        beat(8'd110, 7'h7F, 1'b0);
        beat(8'd111, 7'h7F, 1'b1);
        check_pkt("shift_edges");

        ready_i = 1'b0;
        push_exp(32'h0002_0000, 16'd1, 1'b0);
        beat(8'd128, 7'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_valid", 64'(valid_o), 64'h1);
            chk("stall_ready", 64'(ready_o), 64'h0);
            chk("stall_sum", 64'(sum_o), 64'h0002_0000);
        end
        ready_i = 1'b1;
        check_pkt("stall");

`ifdef EXPU_ACC_SATURATE_EN
        push_exp(32'hFFFF_FFFF, 16'd2, 1'b1);
`else
        push_exp(32'h0000_0000, 16'd2, 1'b1);
`endif
        beat(8'd142, 7'h00, 1'b0);
        beat(8'd142, 7'h00, 1'b1);
        check_pkt("carry_ovf");

`ifdef EXPU_ACC_SATURATE_EN
        push_exp(32'hFFFF_FFFF, 16'd2, 1'b1);
`else
        push_exp(32'h0001_0000, 16'd2, 1'b1);
`endif
        beat(8'd127, 7'h00, 1'b0);
        beat(8'd255, 7'h00, 1'b1);
        check_pkt("exp_ones");

        push_exp(32'h0001_0000, 16'd1, 1'b0);
        beat(8'd127, 7'h00, 1'b1);
        check_pkt("single");

        beat(8'd127, 7'h00, 1'b0);
        beat(8'd127, 7'h00, 1'b0);
        chk("pre_clear_count", 64'(count_o), 64'h2);
        chk("pre_clear_sum", 64'(sum_o), 64'h0002_0000);
        exponent_i = 8'd127;
        mantissa_i = 7'h00;
        valid_i    = 1'b1;
        clear_i    = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        clear_i = 1'b0;
        chk("clear_count", 64'(count_o), 64'h0);
        chk("clear_sum", 64'(sum_o), 64'h0);
        push_exp(32'h0001_0000, 16'd1, 1'b0);
        beat(8'd127, 7'h00, 1'b1);
        check_pkt("after_clear");

        beat(8'd128, 7'h00, 1'b0);
        chk("pre_rst_count", 64'(count_o), 64'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_count", 64'(count_o), 64'h0);
        chk("async_rst_sum", 64'(sum_o), 64'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        push_exp(32'h0001_0000, 16'd1, 1'b0);
        beat(8'd127, 7'h00, 1'b1);
        check_pkt("after_rst");

        chk("sb_drained", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
